// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap, saturate, auto-reload and one-shot
// terminal modes, a registered terminal-count pulse and sticky overflow flag.
module updown_counter #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter logic [WIDTH-1:0] RELOAD_INIT = '0
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             enable_i,
   input  logic             in_load,
   input  logic [WIDTH-1:0] in_data,
   input  logic             up_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic [1:0]       mode_i,
   input  logic             reload_wr_i,
   input  logic [WIDTH-1:0] reload_data_i,
   input  logic             ovf_clr_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             ovf_o,
   output logic             done_o
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_r, count_nxt_s;
   logic [WIDTH-1:0] reload_r, reload_nxt_s;
   logic             tc_r, tc_nxt_s;
   logic             ovf_r, ovf_nxt_s;
   logic             done_r, done_nxt_s;
   logic [WIDTH:0]   sum_s;
   logic             event_s;

   // Extended-width arithmetic: bit WIDTH flags both carry-out and borrow.
   always_comb begin
      if (up_i) begin
         sum_s = {1'b0, count_r} + {1'b0, step_i};
      end else begin
         sum_s = {1'b0, count_r} - {1'b0, step_i};
      end
      event_s = enable_i && !in_load && !done_r && (step_i != '0) && sum_s[WIDTH];
   end

   // Next-state selection for count, flags and reload register.
   always_comb begin
      count_nxt_s  = count_r;
      tc_nxt_s     = 1'b0;
      ovf_nxt_s    = ovf_r & ~ovf_clr_i;
      done_nxt_s   = done_r;
      reload_nxt_s = reload_wr_i ? reload_data_i : reload_r;
      if (in_load) begin
         count_nxt_s = in_data;
         done_nxt_s  = 1'b0;
      end else if (event_s) begin
         tc_nxt_s = 1'b1;
         case (mode_i)
            2'd0: begin
               count_nxt_s = sum_s[WIDTH-1:0];
               ovf_nxt_s   = 1'b1;
            end
            2'd1: begin
               count_nxt_s = up_i ? MAX_VAL : '0;
               ovf_nxt_s   = 1'b1;
            end
            // Uses the pre-write reload value even when reload_wr_i is high.
            2'd2: begin
               count_nxt_s = reload_r;
            end
            2'd3: begin
               count_nxt_s = up_i ? MAX_VAL : '0;
               done_nxt_s  = 1'b1;
            end
            default: begin
               count_nxt_s = count_r;
            end
         endcase
      end else if (enable_i && !done_r) begin
         count_nxt_s = sum_s[WIDTH-1:0];
      end else begin
         count_nxt_s = count_r;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_r  <= RESET_VAL;
         reload_r <= RELOAD_INIT;
         tc_r     <= 1'b0;
         ovf_r    <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         count_r  <= count_nxt_s;
         reload_r <= reload_nxt_s;
         tc_r     <= tc_nxt_s;
         ovf_r    <= ovf_nxt_s;
         done_r   <= done_nxt_s;
      end
   end

   assign count_o = count_r;
   assign tc_o    = tc_r;
   assign ovf_o   = ovf_r;
   assign done_o  = done_r;

endmodule

// File: tb/tb_updown_counter.sv
// Table-driven self-checking bench for updown_counter (WIDTH=4, reset values 0).
module tb_updown_counter;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic       enable_i, in_load, up_i, reload_wr_i, ovf_clr_i;
   logic [3:0] in_data, step_i, reload_data_i;
   logic [1:0] mode_i;
   logic [3:0] count_o;
   logic       tc_o, ovf_o, done_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       ld;
      logic [3:0] data;
      logic       en;
      logic       up;
      logic [3:0] step;
      logic [1:0] mode;
      logic       rwr;
      logic [3:0] rdata;
      logic       clr;
      logic [3:0] e_count;
      logic       e_tc;
      logic       e_ovf;
      logic       e_done;
   } vec_t;

   vec_t vecs[25];

   updown_counter #(.WIDTH(4), .RESET_VAL(4'd0), .RELOAD_INIT(4'd0)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_i(enable_i), .in_load(in_load),
      .in_data(in_data), .up_i(up_i), .step_i(step_i), .mode_i(mode_i),
      .reload_wr_i(reload_wr_i), .reload_data_i(reload_data_i), .ovf_clr_i(ovf_clr_i),
      .count_o(count_o), .tc_o(tc_o), .ovf_o(ovf_o), .done_o(done_o)
   );

   always #5 clk_in = ~clk_in;

   function automatic vec_t v(input logic ld, input logic [3:0] data, input logic en,
                              input logic up, input logic [3:0] step, input logic [1:0] mode,
                              input logic rwr, input logic [3:0] rdata, input logic clr,
                              input logic [3:0] ec, input logic et, input logic eo, input logic ed);
      vec_t r;
      r.ld = ld; r.data = data; r.en = en; r.up = up; r.step = step; r.mode = mode;
      r.rwr = rwr; r.rdata = rdata; r.clr = clr;
      r.e_count = ec; r.e_tc = et; r.e_ovf = eo; r.e_done = ed;
      return r;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] ec, input logic et,
                            input logic eo, input logic ed);
      check({tag, " count"}, count_o, ec);
      check({tag, " tc"}, {3'd0, tc_o}, {3'd0, et});
      check({tag, " ovf"}, {3'd0, ovf_o}, {3'd0, eo});
      check({tag, " done"}, {3'd0, done_o}, {3'd0, ed});
   endtask

   task automatic drive(input vec_t x);
      in_load = x.ld; in_data = x.data; enable_i = x.en; up_i = x.up; step_i = x.step;
      mode_i = x.mode; reload_wr_i = x.rwr; reload_data_i = x.rdata; ovf_clr_i = x.clr;
   endtask

   initial begin
      // wrap down
      vecs[0]  = v(1'b1, 4'd2,  1'b0, 1'b0, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0);
      vecs[1]  = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0);
      vecs[2]  = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      vecs[3]  = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
      vecs[4]  = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b0, 1'b1, 1'b0);
      vecs[5]  = v(1'b0, 4'd0,  1'b0, 1'b0, 4'd1, 2'd0, 1'b0, 4'd0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
      // saturate up, step 3
      vecs[6]  = v(1'b1, 4'd13, 1'b0, 1'b1, 4'd3, 2'd1, 1'b0, 4'd0, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0);
      vecs[7]  = v(1'b0, 4'd0,  1'b1, 1'b1, 4'd3, 2'd1, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
      vecs[8]  = v(1'b0, 4'd0,  1'b1, 1'b1, 4'd3, 2'd1, 1'b0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
      vecs[9]  = v(1'b0, 4'd0,  1'b0, 1'b1, 4'd3, 2'd1, 1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
      // auto-reload down
      vecs[10] = v(1'b1, 4'd1,  1'b0, 1'b0, 4'd1, 2'd2, 1'b1, 4'd9, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0);
      vecs[11] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      vecs[12] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd2, 1'b1, 4'd4, 1'b0, 4'd9,  1'b1, 1'b0, 1'b0);
      vecs[13] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0);
      vecs[14] = v(1'b1, 4'd0,  1'b0, 1'b0, 4'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      vecs[15] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0);
      // one-shot down
      vecs[16] = v(1'b1, 4'd2,  1'b0, 1'b0, 4'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0);
      vecs[17] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0);
      vecs[18] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      vecs[19] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1);
      vecs[20] = v(1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
      vecs[21] = v(1'b1, 4'd5,  1'b1, 1'b0, 4'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0);
      // priority, zero step, wrap up by 9
      vecs[22] = v(1'b1, 4'd7,  1'b1, 1'b1, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0);
      vecs[23] = v(1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0);
      vecs[24] = v(1'b0, 4'd0,  1'b1, 1'b1, 4'd9, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0);

      drive(v(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      rst_n_in = 1'b0;
      #12;
      check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n_in = 1'b1;

      // Reset mid-run: count at 5 with enable high, reset between edges.
      @(posedge clk_in); #1;
      drive(v(1'b1, 4'd5, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      @(posedge clk_in); #1;
      check_all("preload5", 4'd5, 1'b0, 1'b0, 1'b0);
      in_load = 1'b0; enable_i = 1'b1;
      #2 rst_n_in = 1'b0;
      #1 check_all("midrun_rst", 4'd0, 1'b0, 1'b0, 1'b0);
      enable_i = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;

      for (int i = 0; i < 25; i++) begin
         @(posedge clk_in); #1;
         drive(vecs[i]);
         @(posedge clk_in); #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tc, vecs[i].e_ovf, vecs[i].e_done);
         drive(v(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      end

      // Reset during a tc pulse: pulse and flag are aborted at once.
      @(posedge clk_in); #1;
      drive(v(1'b1, 4'd15, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      @(posedge clk_in); #1;
      in_load = 1'b0; enable_i = 1'b1;
      @(posedge clk_in); #1;
      check_all("wrap_up", 4'd0, 1'b1, 1'b1, 1'b0);
      enable_i = 1'b0;
      #2 rst_n_in = 1'b0;
      #1 check_all("pulse_rst", 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter: the next generation of the team's 4-bit loadable down-counter. It adds configurable width, a per-cycle direction and step, and four terminal-count modes (wrap, saturate, auto-reload, one-shot). It also adds a registered terminal-count pulse and a sticky overflow flag. It serves as the general timer/tick source for datapath and control blocks.

## Interface
- WIDTH, 4, counter, load, step and reload width (≥2)
- RESET_VAL, 0, value of count_o after reset
- RELOAD_INIT, 0, value of the reload register after reset
- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- enable_i  input  1  advance counter by step_i this cycle
- in_load  input  1  load in_data into count (priority over enable_i)
- in_data  input  WIDTH  load value
- up_i  input  1  direction: 1 = count up, 0 = count down
- step_i  input  WIDTH  increment/decrement magnitude; 0 = hold, no event
- mode_i  input  2  0 wrap, 1 saturate, 2 auto-reload, 3 one-shot
- reload_wr_i  input  1  write reload_data_i into the reload register
- reload_data_i  input  WIDTH  reload register write data
- ovf_clr_i  input  1  clear sticky ovf_o
- count_o  output  WIDTH  current count
- tc_o  output  1  registered one-cycle terminal-count pulse
- ovf_o  output  1  sticky overflow/underflow flag (wrap and saturate modes)
- done_o  output  1  one-shot expired; counter frozen

## Operation
- Arithmetic is computed at WIDTH+1 bits.
  - Up: r = count + step.
  - Down: r = count − step.
- A terminal event occurs when enable_i=1, in_load=0, done_o=0, step_i≠0 and r is outside [0, 2^WIDTH−1].
- Without an event, count ← r[WIDTH-1:0].
- On an event, behaviour depends on mode:
  - wrap: count ← r mod 2^WIDTH; tc_o pulses; ovf_o set.
  - saturate: count ← MAX (up) or 0 (down); tc_o pulses; ovf_o set.
  - auto-reload: count ← reload register; tc_o pulses; ovf_o unchanged.
  - one-shot: count ← MAX (up) or 0 (down); tc_o pulses; done_o set.
- While done_o=1, enable_i is ignored and the count holds.
- Priority: reset > in_load > enable_i. in_load clears done_o and never produces tc_o.
- reload_wr_i together with an auto-reload event: the event uses the old reload value, and the new value is stored.
- ovf_clr_i in the same cycle as an ovf_o set: set wins.
- mode_i and up_i are sampled every cycle. No state depends on the previous mode except done_o, which only in_load or reset clears.

## Timing
- Async reset, effective immediately on rst_n_in low:
  - count_o = RESET_VAL
  - reload register = RELOAD_INIT
  - tc_o = 0, ovf_o = 0, done_o = 0
- Deassertion is synchronised by the integrating block; the counter acts on the first rising edge with rst_n_in high.
- All outputs are registered; none depend combinationally on inputs.
- Latency: count_o reflects a load or step one clk_in edge after it is sampled.
- tc_o is high for exactly the one cycle in which count_o shows the post-event value. Back-to-back events give back-to-back pulses.
- ovf_o and done_o rise in that same cycle and remain high until cleared.
- Reset asserted mid-count or mid-pulse aborts immediately; no pulse survives reset.

## Test plan
- Reset mid-run: count at 5, enable high, rst_n_in pulled low between edges → count_o=0, tc_o=0, ovf_o=0, done_o=0 without waiting for a clock edge.
- Wrap down (WIDTH=4, mode 0, step 1): load 2, enable 3 cycles → 1, 0, F; tc_o high only with F; ovf_o stays 1; ovf_clr_i → 0.
- Saturate up (mode 1, step 3): load D, enable 2 cycles → F (tc, ovf), F (tc again). ovf_clr_i and an event in the same cycle → ovf_o remains 1.
- Auto-reload down (mode 2): write reload 9, load 1, step 1, enable 3 cycles → 0, 9 (tc), 8; ovf_o stays 0. reload_wr_i=4 on the event cycle → reloads 9, next reload uses 4.
- One-shot (mode 3): load 2, step 1 down, enable 4 cycles → 1, 0, 0 (tc, done), 0 (no tc). Load 5 → count 5, done_o=0.
- Priority/hold: in_load and enable_i together with in_data=7 → 7, no tc. step_i=0 with enable_i → count holds, no tc.
